// File: rtl/comm_recv.sv
// Symbol-stream frame receiver: collects 32 DATA nibbles after an SOF into a
// 128-bit word and offers it to a downstream FIFO, counting words lost to a full FIFO.
module comm_recv #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [5:0]   rx_sym,
    input  logic         full,
    output logic         wr_en,
    output logic [127:0] dout,
    output logic         busy,
    output logic         frame_err,
    output logic [7:0]   drop_cnt
);

    localparam int GW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE
    } state_t;

    state_t        state, state_nxt;
    logic [4:0]    nib_idx, nib_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [GW-1:0] gap_inc;
    logic          err_nxt;
    logic          store;
    logic          is_sof, is_data, is_abort;

    assign is_sof   = rx_valid && (rx_sym[5:4] == 2'b11);
    assign is_data  = rx_valid && (rx_sym[5:4] == 2'b01);
    assign is_abort = rx_valid && (rx_sym[5:4] == 2'b10);
    assign gap_inc  = gap_cnt + GW'(1);

    assign wr_en = (state == ST_WRITE) && !full;
    assign busy  = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        nib_nxt   = nib_idx;
        gap_nxt   = gap_cnt;
        err_nxt   = 1'b0;
        store     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_sof) begin
                    state_nxt = ST_RECV;
                    nib_nxt   = 5'd0;
                    gap_nxt   = '0;
                end
            end
            ST_RECV: begin
                if (is_sof) begin
                    nib_nxt = 5'd0;
                    gap_nxt = '0;
                    err_nxt = 1'b1;
                end else if (is_abort) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end else if (is_data) begin
                    // A DATA symbol always beats a coinciding timeout.
                    store   = 1'b1;
                    gap_nxt = '0;
                    if (nib_idx == 5'd31) begin
                        state_nxt = ST_WRITE;
                        nib_nxt   = 5'd0;
                    end else begin
                        nib_nxt = nib_idx + 5'd1;
                    end
                end else if (gap_inc == GW'(TIMEOUT)) begin
                    state_nxt = ST_IDLE;
                    gap_nxt   = '0;
                    err_nxt   = 1'b1;
                end else begin
                    gap_nxt = gap_inc;
                end
            end
            ST_WRITE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            nib_idx   <= 5'd0;
            gap_cnt   <= '0;
            frame_err <= 1'b0;
            dout      <= '0;
            drop_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            nib_idx   <= nib_nxt;
            gap_cnt   <= gap_nxt;
            frame_err <= err_nxt;
            if (store) begin
                dout[{nib_idx, 2'b00} +: 4] <= rx_sym[3:0];
            end
            if ((state == ST_WRITE) && full && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_comm_recv.sv
// Scoreboard bench for comm_recv: expected words are queued as frames are sent
// and compared against dout whenever wr_en is seen.
module tb_comm_recv;

    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic [5:0]   rx_sym = 6'd0;
    logic         full = 1'b0;
    logic         wr_en;
    logic [127:0] dout;
    logic         busy;
    logic         frame_err;
    logic [7:0]   drop_cnt;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;
    int writes_seen = 0;
    logic prev_err = 1'b0;
    logic [127:0] sb_q[$];

    comm_recv #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_valid(rx_valid),
        .rx_sym(rx_sym),
        .full(full),
        .wr_en(wr_en),
        .dout(dout),
        .busy(busy),
        .frame_err(frame_err),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [1:0] typ, input logic [3:0] nib);
        rx_valid = vld;
        rx_sym   = {typ, nib};
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 4'h0);
    endtask

    task automatic send_nibbles(input logic [127:0] word, input int from, input int upto);
        for (int k = from; k <= upto; k++) applyStimulus(1'b1, 2'b01, word[4*k +: 4]);
    endtask

    // Full frame; the word is queued only if the FIFO is expected to take it.
    task automatic send_frame(input logic [127:0] word, input logic expect_write);
        applyStimulus(1'b1, 2'b11, 4'h0);
        if (expect_write) sb_q.push_back(word);
        send_nibbles(word, 0, 31);
        checkOutput("wr_timing", wr_en, expect_write);
        idle_cycles(1);
        checkOutput("wr_after", wr_en, 1'b0);
    endtask

    always @(negedge clk) begin
        if (frame_err) begin
            err_pulses++;
            checkOutput("err_width", prev_err, 1'b0);
        end
        prev_err = frame_err;
        if (wr_en) begin
            writes_seen++;
            checkOutput("wr_expected", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) checkOutput("dout", dout, sb_q.pop_front());
        end
    end

    initial begin
        logic [127:0] w;
        int e0;
        int w0;

        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_dout", dout, 128'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wr_en", wr_en, 1'b0);
        checkOutput("rst_frame_err", frame_err, 1'b0);
        checkOutput("rst_drop_cnt", drop_cnt, 8'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Basic write
        e0 = err_pulses;
        send_frame(128'hFEDCBA9876543210FEDCBA9876543210, 1'b1);
        checkOutput("basic_err", err_pulses - e0, 0);
        checkOutput("basic_busy", busy, 1'b0);

        // ABORT after 10 nibbles
        applyStimulus(1'b1, 2'b11, 4'h0);
        checkOutput("sof_busy", busy, 1'b1);
        send_nibbles(128'h123456789ABCDEF0, 0, 9);
        applyStimulus(1'b1, 2'b10, 4'h0);
        checkOutput("abort_err", frame_err, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        idle_cycles(1);
        checkOutput("abort_err_clear", frame_err, 1'b0);
        w = {$urandom, $urandom, $urandom, $urandom};
        send_frame(w, 1'b1);

        // Timeout: TIMEOUT idle cycles aborts, TIMEOUT-1 does not
        e0 = err_pulses;
        applyStimulus(1'b1, 2'b11, 4'h0);
        send_nibbles(w, 0, 4);
        idle_cycles(TO);
        idle_cycles(2);
        checkOutput("timeout_err", err_pulses - e0, 1);
        checkOutput("timeout_busy", busy, 1'b0);
        e0 = err_pulses;
        w = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(1'b1, 2'b11, 4'h0);
        send_nibbles(w, 0, 4);
        for (int i = 0; i < TO - 1; i++) applyStimulus(1'b1, 2'b00, 4'hA);
        checkOutput("gap_busy", busy, 1'b1);
        sb_q.push_back(w);
        send_nibbles(w, 5, 31);
        checkOutput("gap_wr", wr_en, 1'b1);
        idle_cycles(1);
        checkOutput("gap_err", err_pulses - e0, 0);
        checkOutput("nodrop_cnt", drop_cnt, 8'd0);

        // SOF restart mid-frame
        e0 = err_pulses;
        applyStimulus(1'b1, 2'b11, 4'h0);
        send_nibbles(w, 0, 19);
        applyStimulus(1'b1, 2'b11, 4'h0);
        checkOutput("restart_err", frame_err, 1'b1);
        checkOutput("restart_busy", busy, 1'b1);
        sb_q.push_back({32{4'h5}});
        send_nibbles({32{4'h5}}, 0, 31);
        checkOutput("restart_wr", wr_en, 1'b1);
        idle_cycles(1);
        checkOutput("restart_err_cnt", err_pulses - e0, 1);

        // Reset mid-frame
        e0 = err_pulses;
        w0 = writes_seen;
        applyStimulus(1'b1, 2'b11, 4'h0);
        send_nibbles(w, 0, 15);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mrst_dout", dout, 128'd0);
        checkOutput("mrst_busy", busy, 1'b0);
        checkOutput("mrst_wr_en", wr_en, 1'b0);
        checkOutput("mrst_frame_err", frame_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_nibbles(w, 0, 31);
        idle_cycles(2);
        checkOutput("mrst_no_wr", writes_seen - w0, 0);
        checkOutput("mrst_no_err", err_pulses - e0, 0);
        w = {$urandom, $urandom, $urandom, $urandom};
        send_frame(w, 1'b1);

        // Full FIFO drops, saturating at 255
        full = 1'b1;
        w0 = writes_seen;
        send_frame(128'hFEDCBA9876543210FEDCBA9876543210, 1'b0);
        checkOutput("drop_one", drop_cnt, 8'd1);
        for (int f = 1; f < 256; f++) send_frame(128'hFEDCBA9876543210FEDCBA9876543210, 1'b0);
        checkOutput("drop_sat", drop_cnt, 8'd255);
        checkOutput("drop_no_wr", writes_seen - w0, 0);
        full = 1'b0;
        send_frame(128'hFEDCBA9876543210FEDCBA9876543210, 1'b1);
        checkOutput("drop_hold", drop_cnt, 8'd255);

        idle_cycles(2);
        checkOutput("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comm_recv.md
COMM_RECV -- requirements
Module: comm_recv

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum idle cycles between data symbols inside a frame before the frame aborts.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 rx_valid  input  1  rx_sym is valid this cycle.
REQ-005 rx_sym  input  6  received symbol: [5:4] type, [3:0] data nibble.
REQ-006 full  input  1  downstream FIFO full.
REQ-007 wr_en  output  1  FIFO write strobe.
REQ-008 dout  output  128  assembled word to FIFO.
REQ-009 busy  output  1  high while a frame is in progress (RECV or WRITE).
REQ-010 frame_err  output  1  one-cycle pulse on a frame abort.
REQ-011 drop_cnt  output  8  count of completed words dropped because full was high; saturates at 255.

Function
REQ-012 Symbol types, decoded only when rx_valid=1:
- 2'b11 = SOF (nibble ignored)
- 2'b01 = DATA
- 2'b10 = ABORT
- 2'b00 = IDLE (no effect except as noted)
REQ-013 FSM states: IDLE, RECV, WRITE; reset state IDLE.
REQ-014 IDLE: SOF -> RECV, with nibble index and gap counter cleared; all other symbols are ignored.
REQ-015 RECV: DATA stores the nibble at dout[4k+3:4k], where k = nibble index 0..31 (first nibble is LSB), then increments k and clears the gap counter.
REQ-016 RECV: when the DATA symbol with k=31 is sampled, go to WRITE on that same edge.
REQ-017 RECV gap counter: increments every cycle without an accepted DATA symbol (IDLE symbols and rx_valid=0 both count).
REQ-018 RECV timeout: when the gap counter reaches TIMEOUT, go to IDLE and pulse frame_err.
REQ-019 RECV, SOF received: restart the frame (k=0, gap=0, stay in RECV) and pulse frame_err.
REQ-020 RECV, ABORT received: go to IDLE and pulse frame_err.
REQ-021 WRITE lasts exactly one cycle, then returns to IDLE; symbols arriving in WRITE are ignored, including SOF.
REQ-022 wr_en = (state==WRITE) && !full, combinational, so it asserts in the cycle immediately after the edge that samples nibble 31.
REQ-023 dout holds the complete word throughout WRITE and keeps it until the next nibble-0 write.
REQ-024 WRITE with full=1: no wr_en, the word is dropped, and drop_cnt increments, saturating at 255.
REQ-025 frame_err is high for exactly one cycle, on the cycle after the triggering edge.
REQ-026 Timeout and DATA in the same cycle: DATA wins and the gap counter clears.
REQ-027 Fewer than 32 nibbles followed by ABORT or timeout: no write occurs and drop_cnt is unchanged.
REQ-028 Throughput: back-to-back frames are allowed, with the next SOF accepted from the first cycle in IDLE.

Reset
REQ-029 RST=0 immediately forces state=IDLE, and clears dout, the nibble index, the gap counter and drop_cnt.
REQ-030 RST=0 immediately forces wr_en=0, busy=0 and frame_err=0.
REQ-031 Reset asserted mid-frame discards the partial frame and generates no frame_err pulse.
REQ-032 After release, the first frame requires a fresh SOF.

Verification
REQ-033 Basic write: reset, SOF, then 32 DATA nibbles 0x0..0xF,0x0..0xF with full=0 -> one wr_en pulse the cycle after the last nibble; dout=128'hFEDCBA9876543210FEDCBA9876543210; frame_err=0.
REQ-034 Full drop: same frame with full=1 held -> wr_en never asserts, drop_cnt=1; repeat 256 frames -> drop_cnt=255.
REQ-035 ABORT: SOF, 10 DATA, ABORT -> frame_err one-cycle pulse, busy=0, no wr_en; next complete frame writes correctly.
REQ-036 Timeout: SOF, 5 DATA, then rx_valid=0 for TIMEOUT cycles -> frame_err pulse, return to IDLE; with only TIMEOUT-1 gap cycles then DATA -> the frame continues normally.
REQ-037 SOF restart: SOF, 20 DATA, SOF, 32 DATA of 0x5 -> one frame_err pulse, then dout all-5s with one wr_en.
REQ-038 Reset mid-frame: SOF, 16 DATA, RST low for 2 cycles -> outputs zero immediately, no wr_en, no frame_err; following frame correct.
